// File: rtl/emif_calbus_arbiter_if.sv
// emif_calbus_if: requester-side and calbus-side signals of the calbus arbiter
interface emif_calbus_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0] req_read, req_write, req_waitrequest, req_rdata_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_rdata, calbus_wdata, calbus_rdata;
  logic [ADDR_WIDTH-1:0] calbus_address;
  logic calbus_read, calbus_write, busy, cmd_err;
  modport master (
    output req_read, req_write, req_address, req_wdata, calbus_rdata,
    input  req_waitrequest, req_rdata, req_rdata_valid, calbus_read, calbus_write,
    input  calbus_address, calbus_wdata, busy, cmd_err
  );
  modport slave (
    input  req_read, req_write, req_address, req_wdata, calbus_rdata,
    output req_waitrequest, req_rdata, req_rdata_valid, calbus_read, calbus_write,
    output calbus_address, calbus_wdata, busy, cmd_err
  );
endinterface

// File: rtl/emif_calbus_arbiter.sv
// emif_calbus_arbiter: round-robin arbiter putting one requester command at a time onto a shared calbus
module emif_calbus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input logic          calbus_clk,
  input logic          calbus_rst,
  emif_calbus_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW:0] N = (PW+1)'(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;
  state_t state_q;
  logic [PW-1:0] rr_ptr_q, owner_q, win, idx;
  logic [PW:0] sum;
  logic [3:0] cnt_q;
  logic found, rd_q, wr_q, cmd_err_q;
  logic [NUM_REQ-1:0] pend, grant, valid_q;
  logic [ADDR_WIDTH-1:0] addr_q, win_addr;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, win_wdata;
  assign pend = bus.req_read | bus.req_write;
  // Scan from the farthest offset down so the nearest pending index at or after rr_ptr wins.
  always_comb begin
    win = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      idx = PW'(sum >= N ? sum - N : sum);
      if (pend[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    win_addr = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == PW'(i)) begin
        win_addr = bus.req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  assign grant = (state_q == IDLE && found && !calbus_rst) ? NUM_REQ'(1) << win : '0;
  assign bus.req_waitrequest = ~grant;
  assign bus.req_rdata = rdata_q;
  assign bus.req_rdata_valid = valid_q;
  assign bus.calbus_read = rd_q;
  assign bus.calbus_write = wr_q;
  assign bus.calbus_address = addr_q;
  assign bus.calbus_wdata = wdata_q;
  assign bus.busy = state_q != IDLE;
  assign bus.cmd_err = cmd_err_q;
  always_ff @(posedge calbus_clk or posedge calbus_rst)
    if (calbus_rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cmd_err_q <= 1'b0;
      valid_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      valid_q <= '0;
      case (state_q)
        IDLE: if (found) begin
          state_q <= ISSUE;
          owner_q <= win;
          rr_ptr_q <= win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1;
          addr_q <= win_addr;
          wdata_q <= win_wdata;
          rd_q <= ~bus.req_write[win];
          wr_q <= bus.req_write[win];
          cmd_err_q <= cmd_err_q | (bus.req_read[win] & bus.req_write[win]);
        end
        ISSUE: begin
          state_q <= wr_q ? IDLE : RD_WAIT;
          cnt_q <= 4'(RD_LATENCY - 1);
        end
        RD_WAIT: if (cnt_q == '0) begin
          state_q <= RESP;
          rdata_q <= bus.calbus_rdata;
          valid_q <= NUM_REQ'(1) << owner_q;
        end else cnt_q <= cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_emif_calbus_arbiter.sv
// tb_emif_calbus_arbiter: vector table plus scoreboard for strobes and read responses,
// with hand sequences for contention, reset during a read and round-robin wrap-around.
module tb_emif_calbus_arbiter;
  localparam int L = 2;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  emif_calbus_if #(.NUM_REQ(2), .ADDR_WIDTH(20), .DATA_WIDTH(32)) a_if ();
  emif_calbus_if #(.NUM_REQ(4), .ADDR_WIDTH(20), .DATA_WIDTH(32)) b_if ();
  emif_calbus_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(20), .DATA_WIDTH(32), .RD_LATENCY(L)) dut_a (
    .calbus_clk(clk), .calbus_rst(rst), .bus(a_if.slave));
  emif_calbus_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(20), .DATA_WIDTH(32), .RD_LATENCY(L)) dut_b (
    .calbus_clk(clk), .calbus_rst(rst), .bus(b_if.slave));

  typedef struct { bit rd; bit wr; int idx; logic [19:0] addr; logic [31:0] wdata; logic [31:0] rdata; bit err; } tv_t;
  typedef struct { int cyc; bit wr; logic [19:0] addr; logic [31:0] wdata; } strobe_t;
  typedef struct { int cyc; int idx; logic [31:0] data; } rresp_t;
  tv_t tv[6];
  strobe_t sq[$];
  rresp_t rq[$];
  int glog[$];
  int ptr_a = 0, free_a = 0, last_a = 0, grants_a = 0, rcnt = 0;
  logic [31:0] cur_rdata = '0, hold_exp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int winner(input logic [3:0] p, input int ptr, input int n);
    for (int k = 0; k < n; k++)
      if (p[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  // Calbus slave model: read data is valid only in cycle strobe+L.
  always @(posedge clk) begin
    #1;
    if (rst) rcnt = 0;
    else begin
      if (rcnt > 0) rcnt--;
      if (a_if.calbus_read) rcnt = L + 1;
    end
    a_if.calbus_rdata = (rcnt == 1) ? cur_rdata : 32'h0BADF00D;
  end

  logic [1:0] pend_a, exp_g, exp_w, vexp;
  int w;
  bit wr;
  strobe_t s;
  rresp_t r;
  always @(negedge clk) begin
    if (rst) begin
      sq.delete();
      rq.delete();
      ptr_a = 0;
      free_a = 0;
      last_a = 0;
    end else begin
      pend_a = a_if.req_read | a_if.req_write;
      exp_g = '0;
      if (cyc >= free_a && pend_a != 0) begin
        w = winner({2'b00, pend_a}, ptr_a, 2);
        exp_g[w] = 1'b1;
        wr = a_if.req_write[w];
        s.cyc = cyc + 1;
        s.wr = wr;
        s.addr = a_if.req_address[w*20 +: 20];
        s.wdata = a_if.req_wdata[w*32 +: 32];
        sq.push_back(s);
        if (!wr) begin
          r.cyc = cyc + 2 + L;
          r.idx = w;
          r.data = cur_rdata;
          rq.push_back(r);
        end
        ptr_a = (w + 1) % 2;
        last_a = cyc;
        free_a = cyc + (wr ? 2 : 3 + L);
        grants_a++;
        glog.push_back(w);
      end
      exp_w = ~exp_g;
      chk("waitrequest", a_if.req_waitrequest, exp_w);
      chk("busy", a_if.busy, cyc > last_a && cyc < free_a);
      if (a_if.calbus_read || a_if.calbus_write) begin
        checks++;
        if (sq.size() == 0) begin
          fails++;
          $display("FAIL strobe: unexpected rd=%0b wr=%0b at cycle %0d", a_if.calbus_read, a_if.calbus_write, cyc);
        end else begin
          s = sq.pop_front();
          chk("strobe_cycle", cyc, s.cyc);
          chk("calbus_write", a_if.calbus_write, s.wr);
          chk("calbus_read", a_if.calbus_read, !s.wr);
          chk("calbus_address", a_if.calbus_address, s.addr);
          if (s.wr) chk("calbus_wdata", a_if.calbus_wdata, s.wdata);
        end
      end
      if (sq.size() != 0 && sq[0].cyc < cyc) begin
        checks++;
        fails++;
        $display("FAIL strobe: missing, due cycle %0d now %0d", sq[0].cyc, cyc);
        void'(sq.pop_front());
      end
      if (a_if.req_rdata_valid != 0) begin
        checks++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL rdata_valid: unexpected %b at cycle %0d", a_if.req_rdata_valid, cyc);
        end else begin
          r = rq.pop_front();
          vexp = '0;
          vexp[r.idx] = 1'b1;
          chk("rdata_cycle", cyc, r.cyc);
          chk("rdata_valid", a_if.req_rdata_valid, vexp);
          chk("req_rdata", a_if.req_rdata, r.data);
        end
      end
      if (rq.size() != 0 && rq[0].cyc < cyc) begin
        checks++;
        fails++;
        $display("FAIL rdata_valid: missing, due cycle %0d now %0d", rq[0].cyc, cyc);
        void'(rq.pop_front());
      end
    end
  end

  task automatic reset_chk(input string tag);
    chk({tag, "_calbus_read"}, a_if.calbus_read, 0);
    chk({tag, "_calbus_write"}, a_if.calbus_write, 0);
    chk({tag, "_calbus_address"}, a_if.calbus_address, 0);
    chk({tag, "_calbus_wdata"}, a_if.calbus_wdata, 0);
    chk({tag, "_req_rdata"}, a_if.req_rdata, 0);
    chk({tag, "_rdata_valid"}, a_if.req_rdata_valid, 0);
    chk({tag, "_waitrequest"}, a_if.req_waitrequest, 2'b11);
    chk({tag, "_busy"}, a_if.busy, 0);
    chk({tag, "_cmd_err"}, a_if.cmd_err, 0);
  endtask

  task automatic xact_a(input tv_t t);
    int tacc;
    bit got;
    @(posedge clk);
    #1;
    cur_rdata = t.rdata;
    a_if.req_address[t.idx*20 +: 20] = t.addr;
    a_if.req_wdata[t.idx*32 +: 32] = t.wdata;
    a_if.req_read[t.idx] = t.rd;
    a_if.req_write[t.idx] = t.wr;
    got = 0;
    tacc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (a_if.req_waitrequest[t.idx] == 1'b0) begin
        got = 1;
        tacc = cyc;
      end
    end
    chk("accept_seen", got, 1);
    @(posedge clk);
    #1;
    a_if.req_read[t.idx] = 1'b0;
    a_if.req_write[t.idx] = 1'b0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (!a_if.busy) got = 1;
    end
    chk("busy_release", cyc - tacc, t.wr ? 2 : 3 + L);
    if (t.rd && !t.wr) hold_exp = t.rdata;
    repeat (3) @(negedge clk);
    chk("cmd_err", a_if.cmd_err, t.err);
    chk("rdata_hold", a_if.req_rdata, hold_exp);
  endtask

  task automatic wait_b(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_if.req_waitrequest != 4'hF) begin
        g = ~b_if.req_waitrequest;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    bit got;
    tv[0] = '{0, 1, 1, 20'h00ABC, 32'hDEADBEEF, 32'h0, 0};
    tv[1] = '{1, 0, 0, 20'h12345, 32'h0, 32'hCAFE0001, 0};
    tv[2] = '{1, 0, 1, 20'hFFFFF, 32'h0, 32'hFFFFFFFF, 0};
    tv[3] = '{0, 1, 0, 20'h00000, 32'h0, 32'h0, 0};
    tv[4] = '{1, 1, 1, 20'h55555, 32'hA5A5A5A5, 32'h0, 1};
    tv[5] = '{1, 0, 0, 20'h00001, 32'h0, 32'h12345678, 1};
    a_if.req_read = '0;
    a_if.req_write = '0;
    a_if.req_address = '0;
    a_if.req_wdata = '0;
    b_if.req_read = '0;
    b_if.req_write = '0;
    b_if.req_address = '0;
    b_if.req_wdata = '0;
    b_if.calbus_rdata = '0;
    repeat (2) @(negedge clk);
    reset_chk("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    foreach (tv[i]) xact_a(tv[i]);

    // Contention: both requesters write continuously right after reset.
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    glog.delete();
    a_if.req_address = {20'h22222, 20'h11111};
    a_if.req_wdata = {32'h2222AAAA, 32'h1111BBBB};
    a_if.req_write = 2'b11;
    repeat (10) @(posedge clk);
    #1 a_if.req_write = 2'b00;
    chk("contention_grants", glog.size(), 5);
    foreach (glog[i]) chk("contention_order", glog[i], i % 2);
    repeat (3) @(posedge clk);

    // Reset asserted while a read from requester 0 sits in RD_WAIT.
    #1;
    cur_rdata = 32'h77777777;
    a_if.req_address[19:0] = 20'h0F0F0;
    a_if.req_read = 2'b01;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (a_if.req_waitrequest[0] == 1'b0) got = 1;
    end
    chk("rst_read_accept", got, 1);
    @(posedge clk);
    #1 a_if.req_read = 2'b11;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 reset_chk("async_reset");
    @(negedge clk);
    reset_chk("held_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_winner", a_if.req_waitrequest, 2'b10);
    @(posedge clk);
    #1 a_if.req_read = 2'b00;
    repeat (10) @(negedge clk);

    // Wrap-around on the four-requester instance: rr_ptr 3 with {0,2} pending.
    @(posedge clk);
    #1 b_if.req_write = 4'b0100;
    wait_b(g);
    chk("b_first_winner", g, 4'b0100);
    @(posedge clk);
    #1 b_if.req_write = 4'b0101;
    wait_b(g);
    chk("wrap_winner", g, 4'b0001);
    @(posedge clk);
    #1;
    wait_b(g);
    chk("ptr_after_wrap", g, 4'b0100);
    @(posedge clk);
    #1 b_if.req_write = 4'b0000;

    repeat (8) @(negedge clk);
    chk("strobes_drained", sq.size(), 0);
    chk("reads_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
